// File: rtl/mp3_pkg.sv
// mp3_pkg
//   Shared definitions for the MP3 stream fetcher: the song address table,
//   the fetch FSM state type and default sizing.
//   song_base(id) / song_len(id) return the ROM byte address and length of
//   one of eight songs. Every entry satisfies base + len <= 2**SONG_AW, so
//   address arithmetic never wraps.
package mp3_pkg;

  localparam int ROM_AW_DEF     = 17;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int SONG_AW        = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [SONG_AW-1:0] song_base(input logic [2:0] id);
    logic [SONG_AW-1:0] b;
    case (id)
      3'd0:    b = 17'h00000;
      3'd1:    b = 17'h00100;
      3'd2:    b = 17'h00200;
      3'd3:    b = 17'h00300;
      3'd4:    b = 17'h00400;
      3'd5:    b = 17'h00500;
      3'd6:    b = 17'h00600;
      default: b = 17'h1FFF0;  // last song ends exactly at the top of the ROM
    endcase
    return b;
  endfunction

  function automatic logic [SONG_AW-1:0] song_len(input logic [2:0] id);
    logic [SONG_AW-1:0] l;
    case (id)
      3'd0:    l = 17'd100;
      3'd1:    l = 17'd40;
      3'd2:    l = 17'd5;
      3'd3:    l = 17'd20;
      3'd4:    l = 17'd0;   // empty slot
      3'd5:    l = 17'd1;
      3'd6:    l = 17'd30;
      default: l = 17'd16;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/mp3_stream_fetch_if.sv
// mp3_stream_fetch_if
//   Bus bundle of the stream fetcher: the synchronous ROM read port and the
//   outgoing byte stream.
//   ROM port : rom_en/rom_addr from the fetcher, rom_data returns exactly one
//              cycle after a cycle with rom_en=1.
//   Stream   : a byte moves on every cycle where dout_valid && dout_ready are
//              both high. Once dout_valid rises, dout and dout_valid hold
//              until that transfer happens (a flush is the only exception:
//              it drops dout_valid without a transfer).
//   master = fetcher side, slave = ROM + consumer side.
interface mp3_stream_fetch_if #(
  parameter int ROM_AW = 17
);
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output rom_en, rom_addr, dout, dout_valid,
    input  rom_data, dout_ready
  );

  modport slave (
    input  rom_en, rom_addr, dout, dout_valid,
    output rom_data, dout_ready
  );
endinterface

// File: rtl/mp3_byte_fifo.sv
// mp3_byte_fifo
//   Show-ahead byte FIFO with registered head outputs.
//   Ports: clk, rst (sync, active low), flush (empties the FIFO, wins over
//   push), push/din (write), ready (consumer accept), dout/dout_valid
//   (registered head), count (entries held, head included).
//   A pop happens on dout_valid && ready. Push and pop may coincide.
//   The caller guarantees no push into a full FIFO without a same-cycle pop.
module mp3_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          ready,
  output logic [7:0]    dout,
  output logic          dout_valid,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic [AW-1:0] rd_ptr_nx;
  logic [CW-1:0] count_nx;
  logic [7:0]    head_nx;

  assign pop = dout_valid & ready;

  // The head register is loaded with what the head will be after this edge,
  // so a byte written into an empty (or emptying) FIFO bypasses the array.
  always_comb begin
    rd_ptr_nx = rd_ptr + AW'(pop);
    count_nx  = count + CW'(push) - CW'(pop);
    head_nx   = mem[rd_ptr_nx];
    if (push && ((count - CW'(pop)) == '0)) head_nx = din;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nx;
      count      <= count_nx;
      dout_valid <= (count_nx != '0);
      if (count_nx != '0) dout <= head_nx;
    end
  end

endmodule

// File: rtl/mp3_stream_fetch.sv
// mp3_stream_fetch
//   Fetches the bytes of one of eight songs from a synchronous ROM and offers
//   them as a byte stream through a small FIFO.
//   Ports: clk, rst (sync, active low), start (level; rising edge launches),
//   music_id (song select), busy (PLAY or DRAIN), song_done (1-cycle pulse
//   after the last byte transfers), state_dbg (FSM state), bus (ROM read
//   port + output stream, master side).
//   Read credit: FIFO entries + reads not yet pushed never exceed
//   FIFO_DEPTH, so the FIFO can never overflow.
module mp3_stream_fetch
  import mp3_pkg::*;
#(
  parameter int ROM_AW     = ROM_AW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          music_id,
  output logic                busy,
  output logic                song_done,
  output state_t              state_dbg,
  mp3_stream_fetch_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [2:0]        id;
  logic [ROM_AW-1:0] off;        // reads issued so far for the current song
  logic              rom_en_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              pending;    // rom_data carries a byte to push this cycle
  logic              start_q;
  logic              song_done_q;

  logic              start_rise;
  logic              active;
  logic              abort;
  logic              change;
  logic              flush;
  logic              pop;
  logic              launch;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_nx;
  logic [CW-1:0]     occ_nx;
  logic              can_issue;
  logic              drain_done;
  logic [7:0]        fifo_dout;
  logic              fifo_valid;

  assign start_rise = start & ~start_q;
  assign active     = (state != IDLE);
  assign abort      = active & ~start;
  assign change     = active & start & (music_id != id);
  assign flush      = abort | change;
  assign launch     = change | ((state == IDLE) & start_rise);
  assign pop        = fifo_valid & bus.dout_ready;

  // FIFO level after this edge, plus the read issued this cycle (it turns
  // into the pending return next cycle). A new read is allowed only if it
  // still fits.
  assign count_nx   = fifo_count + CW'(pending) - CW'(pop);
  assign occ_nx     = count_nx + CW'(rom_en_q);
  assign can_issue  = (occ_nx < CW'(FIFO_DEPTH));
  assign drain_done = ~pending & ~rom_en_q & (count_nx == '0);

  mp3_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (pending),
    .din        (bus.rom_data),
    .ready      (bus.dout_ready),
    .dout       (fifo_dout),
    .dout_valid (fifo_valid),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      id          <= '0;
      off         <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      pending     <= 1'b0;
      start_q     <= start;
      song_done_q <= 1'b0;
    end else begin
      start_q     <= start;
      song_done_q <= 1'b0;
      rom_en_q    <= 1'b0;
      pending     <= rom_en_q;
      if (abort) begin
        state   <= IDLE;
        pending <= 1'b0;
      end else if (launch) begin
        id      <= music_id;
        pending <= 1'b0;
        if (song_len(music_id) == '0) begin
          state       <= IDLE;
          song_done_q <= 1'b1;
        end else begin
          // First read goes out in the cycle PLAY becomes visible.
          state      <= PLAY;
          rom_en_q   <= 1'b1;
          rom_addr_q <= ROM_AW'(song_base(music_id));
          off        <= ROM_AW'(1);
        end
      end else begin
        case (state)
          PLAY: begin
            if (off == ROM_AW'(song_len(id))) begin
              state <= DRAIN;
            end else if (can_issue) begin
              rom_en_q   <= 1'b1;
              rom_addr_q <= ROM_AW'(song_base(id)) + off;
              off        <= off + ROM_AW'(1);
            end
          end
          DRAIN: begin
            if (drain_done) begin
              state       <= IDLE;
              song_done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rom_en     = rom_en_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.dout       = fifo_dout;
  assign bus.dout_valid = fifo_valid;
  assign busy           = active;
  assign song_done      = song_done_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mp3_stream_fetch.sv
module tb_mp3_stream_fetch;
  import mp3_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] music_id;
  logic       busy;
  logic       song_done;
  state_t     state_dbg;

  mp3_stream_fetch_if #(.ROM_AW(17)) bus ();

  mp3_stream_fetch #(
    .ROM_AW     (17),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .music_id  (music_id),
    .busy      (busy),
    .song_done (song_done),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ROM model: byte value derived from its address
  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_byte(bus.rom_addr);
  end

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int outstanding = 0;
  int done_cnt    = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dout  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: compares every transferred byte against the expected queue
  always @(negedge clk) begin
    if (rst) begin
      logic [7:0] e;
      logic       xfer;
      xfer = bus.dout_valid && bus.dout_ready;
      if (prev_stall && bus.dout_valid) check("dout_stable", {24'b0, bus.dout}, {24'b0, prev_dout});
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'b0, bus.dout}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("stream_byte", {24'b0, bus.dout}, {24'b0, e});
        end
      end
      if (bus.rom_en) outstanding++;
      if (xfer) outstanding--;
      if (bus.rom_en) check("outstanding_le_depth", 32'(outstanding <= DEPTH), 32'd1);
      if (song_done) done_cnt++;
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic queue_song(input logic [2:0] s);
    logic [16:0] b;
    logic [16:0] l;
    b = song_base(s);
    l = song_len(s);
    for (int i = 0; i < int'(l); i++) exp_q.push_back(rom_byte(b + 17'(i)));
  endtask

  task automatic launch(input logic [2:0] s);
    music_id = s;
    start    = 1'b1;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output int en_cnt,
                           output logic [16:0] last_addr, output bit seen);
    en_cnt    = 0;
    last_addr = '0;
    seen      = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.rom_en) begin
        en_cnt++;
        last_addr = bus.rom_addr;
      end
      if (song_done) begin
        seen = 1'b1;
        break;
      end
      if (toggle) bus.dout_ready = ~bus.dout_ready;
    end
  endtask

  task automatic idle_gap();
    start = 1'b0;
    bus.dout_ready = 1'b1;
    tick();
    tick();
  endtask

  // stimulus
  initial begin
    int          en_cnt;
    logic [16:0] last_addr;
    bit          seen;
    int          dc;

    rst = 1'b0;
    start = 1'b1;
    music_id = 3'd0;
    bus.dout_ready = 1'b0;
    bus.rom_data = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_rom_en", 32'(bus.rom_en), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_song_done", 32'(song_done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    // start held high through reset must not launch
    repeat (3) begin
      tick();
      check("no_launch_busy", 32'(busy), 32'd0);
      check("no_launch_rom_en", 32'(bus.rom_en), 32'd0);
    end
    idle_gap();

    // basic stream: song 2, 5 bytes at 0x200
    bus.dout_ready = 1'b1;
    queue_song(3'd2);
    launch(3'd2);   // cycle N
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("basic_rom_en", 32'(bus.rom_en), 32'(k <= 5));
      if (k <= 5) check("basic_rom_addr", 32'(bus.rom_addr), 32'h200 + 32'(k - 1));
      check("basic_dout_valid", 32'(bus.dout_valid), 32'(k >= 3 && k <= 7));
      check("basic_song_done", 32'(song_done), 32'(k == 8));
      check("basic_busy", 32'(busy), 32'(k <= 7));
    end
    check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_gap();

    // backpressure: song 6, stall 10 cycles mid-song
    queue_song(3'd6);
    launch(3'd6);
    repeat (8) tick();
    bus.dout_ready = 1'b0;
    repeat (10) tick();
    check("bp_reads_stopped", 32'(bus.rom_en), 32'd0);
    check("bp_dout_valid", 32'(bus.dout_valid), 32'd1);
    bus.dout_ready = 1'b1;
    wait_done(100, 1'b0, en_cnt, last_addr, seen);
    check("bp_song_done_seen", 32'(seen), 32'd1);
    check("bp_last_addr", 32'(last_addr), 32'h61D);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_gap();

    // abort: song 0 (100 bytes), start drops while byte 2 is on dout
    dc = done_cnt;
    queue_song(3'd0);
    launch(3'd0);             // cycle N
    repeat (5) tick();        // cycle N+5: byte 2 transfers
    check("abort_byte2_on_dout", 32'(bus.dout), 32'(rom_byte(17'h2)));
    start = 1'b0;
    tick();                   // K+1
    exp_q.delete();
    outstanding = 0;
    check("abort_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rom_en", 32'(bus.rom_en), 32'd0);
    repeat (5) begin
      tick();
      check("abort_rom_en_quiet", 32'(bus.rom_en), 32'd0);
      check("abort_valid_quiet", 32'(bus.dout_valid), 32'd0);
    end
    check("abort_no_song_done", 32'(done_cnt), 32'(dc));
    idle_gap();

    // song change: song 1 -> song 3 mid-stream
    queue_song(3'd1);
    launch(3'd1);
    repeat (6) tick();        // cycle K
    music_id = 3'd3;
    tick();                   // K+1
    exp_q.delete();
    outstanding = 0;
    queue_song(3'd3);
    check("chg_dout_valid_k1", 32'(bus.dout_valid), 32'd0);
    check("chg_rom_en_k1", 32'(bus.rom_en), 32'd1);
    check("chg_rom_addr_k1", 32'(bus.rom_addr), 32'h300);
    check("chg_busy_k1", 32'(busy), 32'd1);
    tick();                   // K+2
    check("chg_dout_valid_k2", 32'(bus.dout_valid), 32'd0);
    tick();                   // K+3
    check("chg_dout_valid_k3", 32'(bus.dout_valid), 32'd1);
    check("chg_first_byte", 32'(bus.dout), 32'(rom_byte(17'h300)));
    wait_done(100, 1'b0, en_cnt, last_addr, seen);
    check("chg_song_done_seen", 32'(seen), 32'd1);
    check("chg_last_addr", 32'(last_addr), 32'h313);
    check("chg_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_gap();

    // zero-length song 4
    launch(3'd4);
    tick();
    check("zero_song_done", 32'(song_done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_rom_en", 32'(bus.rom_en), 32'd0);
    tick();
    check("zero_song_done_pulse", 32'(song_done), 32'd0);
    check("zero_rom_en_after", 32'(bus.rom_en), 32'd0);
    idle_gap();

    // one-byte song 5 with ready toggling every cycle
    bus.dout_ready = 1'b0;
    queue_song(3'd5);
    launch(3'd5);
    wait_done(40, 1'b1, en_cnt, last_addr, seen);
    check("one_song_done_seen", 32'(seen), 32'd1);
    check("one_rom_en_count", 32'(en_cnt), 32'd1);
    check("one_addr", 32'(last_addr), 32'h500);
    check("one_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_gap();

    // song 7 ends at the top of the ROM address space
    queue_song(3'd7);
    launch(3'd7);
    wait_done(100, 1'b0, en_cnt, last_addr, seen);
    check("top_song_done_seen", 32'(seen), 32'd1);
    check("top_rom_en_count", 32'(en_cnt), 32'd16);
    check("top_last_addr", 32'(last_addr), 32'h1FFFF);
    check("top_queue_empty", 32'(exp_q.size()), 32'd0);
    idle_gap();

    // basic, backpressure, change, zero, one-byte, top: six completions
    check("total_song_done", 32'(done_cnt), 32'd6);
    check("final_state_idle", 32'(state_dbg), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
